// File: rtl/jpeg_block_reader.sv
// jpeg_block_reader: reads a raster 16-bit frame buffer and streams its bytes in 8x8-block order.
// Partial edge blocks are clipped; a 2-entry FIFO decouples the 1-cycle RAM from the ready/valid output.
module jpeg_block_reader #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 200,
  parameter int WSZ    = 9,
  parameter int HSZ    = 8,
  parameter int ASZ    = 17
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [ASZ-1:0] rd_addr,
  output logic           rd_en,
  input  logic [7:0]     rd_data,
  output logic           px_valid,
  output logic [7:0]     px_data,
  output logic           px_last,
  input  logic           px_ready
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [WSZ-1:0] col, col_x;
  logic [HSZ-1:0] row, row_y;
  logic lsb, inflight, inflight_last, wptr, rptr, pop, col_end, row_end, last_issue;
  logic [1:0] count;
  logic [2:0] occ;
  logic [8:0] mem [2];
  assign pop        = px_valid && px_ready;
  assign px_valid   = count != 2'd0;
  assign {px_last, px_data} = px_valid ? mem[rptr] : 9'd0;
  assign occ        = 3'(count) + 3'(inflight) - 3'(pop);
  assign rd_en      = state == RUN && !abort && occ < 3'd2;
  // block-local end detection: columns/rows are absolute and blocks start on multiples of 8
  assign col_end    = col == WSZ'(WIDTH - 1) || col[2:0] == 3'd7;
  assign row_end    = row == HSZ'(HEIGHT - 1) || row[2:0] == 3'd7;
  assign last_issue = lsb && col == WSZ'(WIDTH - 1) && row == HSZ'(HEIGHT - 1);
  assign rd_addr    = ASZ'(row) * ASZ'(2 * WIDTH) + ASZ'({col, lsb});
  assign busy       = state == RUN || state == DRAIN;
  assign done       = state == DONE;
  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else
      case (state)
        IDLE:    if (start) state_nx = RUN;
        RUN:     if (rd_en && last_issue) state_nx = DRAIN;
        DRAIN:   if (!inflight && count == {1'b0, pop}) state_nx = DONE;
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || state == IDLE) begin
      {col, col_x, row, row_y, lsb} <= '0;
    end else if (rd_en) begin
      lsb <= !lsb;
      if (lsb) begin
        if (!col_end) col <= col + 1'b1;
        else if (!row_end) begin
          col <= col_x;
          row <= row + 1'b1;
        end else if (col != WSZ'(WIDTH - 1)) begin
          col_x <= col_x + WSZ'(8);
          col   <= col_x + WSZ'(8);
          row   <= row_y;
        end else begin
          col_x <= '0;
          col   <= '0;
          row_y <= row_y + HSZ'(8);
          row   <= row_y + HSZ'(8);
        end
      end
    end
  // abort discards both the queued bytes and the read still in flight
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || abort) begin
      {inflight, inflight_last, wptr, rptr} <= '0;
      count <= '0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= last_issue;
      if (inflight) wptr <= !wptr;
      if (pop) rptr <= !rptr;
      count <= count + 2'(inflight) - 2'(pop);
    end
  always_ff @(posedge clk)
    if (inflight) mem[wptr] <= {inflight_last, rd_data};
endmodule

// File: tb/tb_jpeg_block_reader.sv
// tb_jpeg_block_reader: three readers (16x8, 12x10, 1x1) sharing control inputs, checked against a
// nested-loop traversal model plus hand-computed vectors and multi-cycle corner sequences.
module tb_jpeg_block_reader;
  logic clk = 0, reset_n = 0, start = 0, abort = 0, px_ready = 0, clr = 0;
  logic [2:0] busy, done, rd_en, px_valid, px_last;
  logic [8:0] rd_addr [3];
  logic [7:0] rd_data [3];
  logic [7:0] px_data [3];
  int checks = 0, failures = 0;
  int n [3], outst [3], ndone [3], tot [3];
  int viol = 0, unstable = 0, doneviol = 0;
  logic prev_stall [3], prev_lx [3];
  logic [7:0] prev_d [3];
  logic [8:0] got [3][512];
  logic [8:0] expv [3][512];
  typedef struct {int g; int k; int exp;} vec_t;
  vec_t tv [15];
  always #5 clk = ~clk;
  for (genvar i = 0; i < 3; i++) begin : u
    jpeg_block_reader #(.WIDTH(i == 0 ? 16 : i == 1 ? 12 : 1), .HEIGHT(i == 0 ? 8 : i == 1 ? 10 : 1),
                        .WSZ(4), .HSZ(4), .ASZ(9)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .busy(busy[i]), .done(done[i]),
      .rd_addr(rd_addr[i]), .rd_en(rd_en[i]), .rd_data(rd_data[i]), .px_valid(px_valid[i]),
      .px_data(px_data[i]), .px_last(px_last[i]), .px_ready(px_ready));
  end
  // frame-buffer model: RAM[a] = a[7:0], one-cycle registered read
  always @(posedge clk)
    for (int g = 0; g < 3; g++) if (rd_en[g]) rd_data[g] <= rd_addr[g][7:0];
  always @(negedge clk) begin
    int p;
    for (int g = 0; g < 3; g++) begin
      if (clr || abort || !reset_n) begin
        n[g] = 0; outst[g] = 0; prev_stall[g] = 0; prev_lx[g] = 0;
        if (clr) ndone[g] = 0;
      end else begin
        p = (px_valid[g] && px_ready) ? 1 : 0;
        if (rd_en[g] && outst[g] - p >= 2) viol++;
        if (prev_stall[g] && (!px_valid[g] || px_data[g] != prev_d[g])) unstable++;
        if (done[g] != prev_lx[g]) doneviol++;
        ndone[g] += int'(done[g]);
        if (p == 1 && n[g] < 512) begin
          got[g][n[g]] = {px_last[g], px_data[g]};
          n[g]++;
        end
        outst[g] += int'(rd_en[g]) - p;
        prev_stall[g] = px_valid[g] && !px_ready;
        prev_d[g] = px_data[g];
        prev_lx[g] = p == 1 && px_last[g];
      end
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int wv(input int g); return g == 0 ? 16 : g == 1 ? 12 : 1; endfunction
  function automatic int hv(input int g); return g == 0 ? 8 : g == 1 ? 10 : 1; endfunction
  task automatic build_model();
    for (int g = 0; g < 3; g++) begin
      int k, a;
      k = 0;
      for (int by = 0; by < hv(g); by += 8)
        for (int bx = 0; bx < wv(g); bx += 8)
          for (int r = by; r < hv(g) && r < by + 8; r++)
            for (int c = bx; c < wv(g) && c < bx + 8; c++)
              for (int b = 0; b < 2; b++) begin
                a = 2 * (r * wv(g) + c) + b;
                expv[g][k] = {a == 2 * wv(g) * hv(g) - 1, 8'(a)};
                k++;
              end
      tot[g] = k;
    end
  endtask
  function automatic int stream_bad(input int g);
    int b = 0;
    for (int k = 0; k < tot[g]; k++) if (got[g][k] !== expv[g][k]) b++;
    return b;
  endfunction
  task automatic wait_done(input bit rnd);
    int c = 0;
    while (!(ndone[0] > 0 && ndone[1] > 0 && ndone[2] > 0) && c < 4000) begin
      @(posedge clk) #1 px_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      c++;
    end
    chk("done_timeout", int'(c < 4000), 1);
    repeat (3) @(posedge clk);
    #1 px_ready = 1;
  endtask
  task automatic frame(input bit rnd);
    @(posedge clk) #1 clr = 1; start = 1;
    @(posedge clk) #1 clr = 0; start = 0;
    wait_done(rnd);
  endtask
  task automatic check_frame(input string tag);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("%s_bytes%0d", tag, g), n[g], tot[g]);
      chk($sformatf("%s_stream%0d", tag, g), stream_bad(g), 0);
      chk($sformatf("%s_ndone%0d", tag, g), ndone[g], 1);
    end
  endtask
  task automatic apply_table(input string tag);
    for (int i = 0; i < 15; i++)
      chk($sformatf("%s_vec%0d", tag, i), int'(got[tv[i].g][tv[i].k]), tv[i].exp);
  endtask
  initial begin
    #1000000 $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tv[0]  = '{0, 0, 0};     tv[1]  = '{0, 15, 15};   tv[2]  = '{0, 16, 32};
    tv[3]  = '{0, 127, 239}; tv[4]  = '{0, 128, 16};  tv[5]  = '{0, 255, 511};
    tv[6]  = '{1, 128, 16};  tv[7]  = '{1, 135, 23};  tv[8]  = '{1, 136, 40};
    tv[9]  = '{1, 192, 192}; tv[10] = '{1, 208, 216}; tv[11] = '{1, 224, 208};
    tv[12] = '{1, 239, 495}; tv[13] = '{2, 0, 0};     tv[14] = '{2, 1, 257};
    build_model();
    chk("model_total0", tot[0], 256);
    chk("model_total1", tot[1], 240);
    chk("model_total2", tot[2], 2);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(px_valid), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_addr", int'(rd_addr[0]), 0);
    @(posedge clk) #1 reset_n = 1; px_ready = 1;
    // latency: start in cycle 0, rd_en in cycle 1, px_valid in cycle 3; restart while busy is ignored
    @(posedge clk) #1 clr = 1; start = 1;
    @(negedge clk) chk("lat_c0_busy", int'(busy[0]), 0);
    @(posedge clk) #1 clr = 0; start = 0;
    @(negedge clk) chk("lat_c1_rd_en", int'(rd_en[0]), 1);
    chk("lat_c1_busy", int'(busy[0]), 1);
    chk("lat_c1_addr", int'(rd_addr[0]), 0);
    chk("lat_c1_valid", int'(px_valid[0]), 0);
    @(negedge clk) chk("lat_c2_valid", int'(px_valid[0]), 0);
    chk("lat_c2_addr", int'(rd_addr[0]), 1);
    @(negedge clk) chk("lat_c3_valid", int'(px_valid[0]), 1);
    chk("lat_c3_data", int'(px_data[0]), 0);
    @(posedge clk) #1 start = 1;
    @(posedge clk) #1 start = 0;
    wait_done(0);
    check_frame("run1");
    apply_table("run1");
    frame(1);
    check_frame("rnd");
    apply_table("rnd");
    // abort while stalled after about 100 bytes
    begin
      int c = 0;
      @(posedge clk) #1 clr = 1; start = 1;
      @(posedge clk) #1 clr = 0; start = 0;
      while (n[0] < 100 && c < 2000) begin
        @(posedge clk) #1 px_ready = 1'($urandom_range(1));
        c++;
      end
      chk("abort_reach", int'(c < 2000), 1);
    end
    @(posedge clk) #1 px_ready = 0;
    @(posedge clk);
    @(negedge clk) chk("stall_valid", int'(px_valid[0]), 1);
    @(posedge clk) #1 abort = 1;
    @(posedge clk) #1 abort = 0;
    @(negedge clk) chk("abort_busy", int'(busy[1:0]), 0);
    chk("abort_valid", int'(px_valid[1:0]), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk) #1 start = 1; abort = 1; px_ready = 1;
    @(posedge clk) #1 start = 0; abort = 0;
    @(negedge clk) chk("start_abort_idle", int'(busy), 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done0", ndone[0], 0);
    chk("abort_no_done1", ndone[1], 0);
    frame(0);
    check_frame("after_abort");
    // asynchronous reset mid-frame
    @(posedge clk) #1 clr = 1; start = 1;
    @(posedge clk) #1 clr = 0; start = 0;
    repeat (50) @(posedge clk);
    #2 reset_n = 0;
    #1 chk("amid_busy", int'(busy), 0);
    chk("amid_valid", int'(px_valid), 0);
    chk("amid_rd_en", int'(rd_en), 0);
    chk("amid_last", int'(px_last), 0);
    chk("amid_data", int'(px_data[0]), 0);
    chk("amid_addr", int'(rd_addr[0]), 0);
    @(posedge clk) #1 reset_n = 1;
    @(negedge clk) chk("post_rst_valid", int'(px_valid), 0);
    frame(0);
    check_frame("after_reset");
    chk("no_overissue", viol, 0);
    chk("stall_stable", unstable, 0);
    chk("done_timing", doneviol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jpeg_block_reader.md
Name: jpeg_block_reader

Overview:
- Reads a raster-order 16-bit-per-pixel frame buffer (2 bytes/pixel, low byte at even address) and emits the bytes in 8x8-block (MCU) order to the JPEG encoder input.
- Exact read-side counterpart of the encoder-output block writer: it uses the same address formula and the same edge clipping, but produces a ready/valid byte stream.
- Sits between the frame-buffer read port (1-cycle registered-read RAM) and the encoder pixel input.

Parameters:
- WIDTH, 320, frame width in pixels (any value >= 1, not necessarily a multiple of 8)
- HEIGHT, 200, frame height in pixels (any value >= 1)
- WSZ, 9, column counter width; must hold WIDTH-1
- HSZ, 8, row counter width; must hold HEIGHT-1
- ASZ, 17, byte address width; must hold 2*WIDTH*HEIGHT-1

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: begin a frame read; ignored while busy
- abort  in  1  synchronous: cancel the frame, flush, return to IDLE, no done
- busy  out  1  high from the cycle after accepted start until done or abort
- done  out  1  one-cycle pulse after the last byte is accepted downstream
- rd_addr  out  ASZ  frame-buffer byte address
- rd_en  out  1  read strobe; rd_data is valid in the following cycle
- rd_data  in  8  frame-buffer read data
- px_valid  out  1  output byte valid
- px_data  out  8  output byte
- px_last  out  1  qualifies the final byte of the frame
- px_ready  in  1  downstream accept; a transfer occurs when px_valid && px_ready

Behaviour:
- Reset: asynchronous on reset_n low (clock clk). All outputs are 0; state=IDLE; counters, FIFO and in-flight flag are cleared.
- FSM states:
  - IDLE: start -> RUN. All counters clear to 0.
  - RUN: issues reads. When the last address is issued -> DRAIN.
  - DRAIN: waits until FIFO empty and no read in flight -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - abort in any non-IDLE state -> IDLE next cycle. FIFO is flushed, px_valid=0, the in-flight read is discarded, done is not pulsed. abort has priority over every other event.
- Traversal order (nested, outermost first):
  - block row row_y = 0, 8, 16, ...
  - block column col_x = 0, 8, ...
  - row in block: row_y .. min(row_y+7, HEIGHT-1)
  - column in block: col_x .. min(col_x+7, WIDTH-1)
  - byte lsb 0 then 1
- Edge clipping: partial edge blocks emit only the existing pixels. There is no padding or replication.
- Address: rd_addr = {row*WIDTH, 1'b0} + {col, lsb}, computed at ASZ bits. It is driven combinationally from the counters and is valid whenever rd_en=1.
- Read issue: rd_en=1 in RUN when (fifo_count + inflight - pop) < 2, where pop = px_valid && px_ready in the current cycle. Counters advance on each rd_en.
- Read return: data is captured into a 2-entry FIFO in the cycle after rd_en.
- Output: px_data/px_valid come from the FIFO head and are held stable while px_valid && !px_ready. px_last=1 only with the final byte (address 2*WIDTH*HEIGHT-1).
- Latency and throughput:
  - start in cycle 0 -> first rd_en in cycle 1 -> first px_valid in cycle 3.
  - With px_ready held at 1: one byte per cycle sustained, with no bubbles.
- Total bytes per frame = 2*WIDTH*HEIGHT. done pulses the cycle after the px_last transfer.
- Simultaneous events:
  - start while busy or during DONE is ignored.
  - start together with abort in IDLE: abort wins and start is ignored.
  - A push and a pop in the same cycle with FIFO full is legal; count is unchanged.
- FIFO never overflows; underflow is impossible by construction. Either event is an assertion failure in verification.

Test Plan:
- WIDTH=16, HEIGHT=8, px_ready=1, RAM[a]=a[7:0] -> rd_addr sequence 0..15, 32..47, …, 224..239, then 16..31, 48..63, …; 256 bytes; px_last on byte at address 255; done 1 cycle later; first px_valid 3 cycles after start.
- WIDTH=12, HEIGHT=10 -> 240 bytes total:
  - block (col_x=8, row_y=0) emits addresses 16..23, then 40..47;
  - block (0,8) emits rows 8–9 only;
  - last address 239 with px_last=1.
- px_ready toggling randomly (50%) with WIDTH=16, HEIGHT=8 -> byte stream identical to the px_ready=1 run; px_data is stable while stalled; rd_en never issued when 2 bytes are held/in flight.
- abort asserted at byte 100 mid-stall -> busy=0 and px_valid=0 next cycle, no done; a new start produces the full 256-byte stream from address 0.
- start pulsed again while busy -> ignored, stream unaffected. Reset_n asserted mid-frame -> all outputs 0 immediately; FIFO empty after release.
- WIDTH=1, HEIGHT=1 -> exactly 2 bytes (addresses 0, 1); px_last on byte 2; done pulse.
